// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel receive stage.
// Optional feature macro: SIPO_PARITY_EN (adds the PAR state and par_err).
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } sipo_state_t;

  localparam int SIPO_MIN_WIDTH = 2;

  // XOR reduction; callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic even_par(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sipo_deser_word_slot.sv
// One-deep valid/ready output register. A word offered while the slot is
// full and not being drained is dropped and raises a sticky overrun flag.
module sipo_word_slot
  import sipo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  input  logic         clr_ovr,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overrun
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;

  // Slot update: load (including back-to-back replace), drop-on-full, or drain.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (load_valid) begin
      if (!valid_q || ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        // Set is applied after the clear so it wins on a coincident edge.
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel receive stage: rebuilds MSB-first serial words framed
// by sof into WIDTH-bit words, presented through a one-deep valid/ready slot.
// Optional feature macro: SIPO_PARITY_EN (trailing even-parity bit, par_err).
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
`ifdef SIPO_PARITY_EN
  output logic             par_err,
`endif
  input  logic             clr_ovr
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
  // The whole data word must be held while waiting for the parity bit.
  localparam int SHREG_W = WIDTH;
  localparam int SLOT_W  = WIDTH + 1;
`else
  // The last bit goes straight to the slot, so only WIDTH-1 bits are held.
  localparam int SHREG_W = WIDTH - 1;
  localparam int SLOT_W  = WIDTH;
`endif

  sipo_state_t        state_q, state_d;
  logic [SHREG_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic               done;
  logic [WIDTH-1:0]   done_word;
  logic [WIDTH-1:0]   shift_word;
  logic [SLOT_W-1:0]  slot_in, slot_out;
`ifdef SIPO_PARITY_EN
  logic               done_perr;
`endif

  assign shift_word = {shreg_q[WIDTH-2:0], sin};

  // Framing FSM: next state, shift register, bit counter and completion strobe.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    done_word = shift_word;
`ifdef SIPO_PARITY_EN
    done_perr = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sin_en && sof) begin
          shreg_d = SHREG_W'(sin);
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_en) begin
          if (sof) begin
            shreg_d = SHREG_W'(sin);
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
            shreg_d = SHREG_W'(shift_word);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = PAR;
`else
            done    = 1'b1;
            shreg_d = SHREG_W'(shift_word);
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            shreg_d = SHREG_W'(shift_word);
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PAR: begin
        if (sin_en) begin
          if (sof) begin
            shreg_d = SHREG_W'(sin);
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end else begin
            done      = 1'b1;
            done_word = shreg_q;
            done_perr = even_par(32'(shreg_q)) ^ sin;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM, shift register, counter and busy decode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SIPO_PARITY_EN
  assign slot_in         = {done_perr, done_word};
  assign {par_err, dout} = slot_out;
`else
  assign slot_in = done_word;
  assign dout    = slot_out;
`endif

  sipo_word_slot #(
    .W(SLOT_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(done),
    .load_data (slot_in),
    .ready     (dout_ready),
    .clr_ovr   (clr_ovr),
    .data      (slot_out),
    .valid     (dout_valid),
    .overrun   (overrun)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=4). Expected words are pushed to
// a scoreboard queue as frames are driven and popped when dout_valid shows.
// Builds with or without SIPO_PARITY_EN.
module tb_sipo_deser;
  import sipo_pkg::*;

`ifdef SIPO_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0;
  logic       sin_en = 1'b0;
  logic       sof = 1'b0;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       busy;
  logic       overrun;
  logic       clr_ovr = 1'b0;
`ifdef SIPO_PARITY_EN
  logic       par_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_w;

  sipo_deser #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_en    (sin_en),
    .sof       (sof),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .overrun   (overrun),
`ifdef SIPO_PARITY_EN
    .par_err   (par_err),
`endif
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  // Bit i of a frame on the wire: data MSB first, then even parity if built in.
  function automatic logic frame_bit(input logic [3:0] w, input int i);
    if (i < 4) return w[3-i];
    return ^w;
  endfunction

  // Apply one cycle of serial input; outputs are sampled 1 ns after the edge.
  task automatic drive(input logic en, input logic s, input logic b);
    sin_en = en;
    sof    = s;
    sin    = b;
    @(posedge clk);
    #1;
    sin_en = 1'b0;
    sof    = 1'b0;
    sin    = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] w);
    for (int i = 0; i < FL; i++) drive(1'b1, (i == 0), frame_bit(w, i));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({dout, dout_valid, busy, overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state: got dout=%h v=%b busy=%b ovr=%b, expected all 0", dout, dout_valid, busy, overrun);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    $display("tb: reset released");
  endtask

  task automatic test_basic;
    logic [3:0] w;
    w = 4'hB;
    dout_ready = 1'b1;
    exp_q.push_back(w);
    for (int i = 0; i < FL; i++) begin
      drive(1'b1, (i == 0), frame_bit(w, i));
      if (i < FL - 1) begin
        vectors++;
        if (busy !== 1'b1 || dout_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_busy_edge%0d: got busy=%b v=%b, expected busy=1 v=0", i + 1, busy, dout_valid);
        end
      end
    end
    exp_w = exp_q.pop_front();
    vectors++;
    if (dout_valid !== 1'b1 || dout !== exp_w || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_word: got v=%b dout=%h busy=%b, expected v=1 dout=%h busy=0", dout_valid, dout, busy, exp_w);
    end
    $display("tb: basic frame dout=%h", dout);
    drive(1'b0, 1'b0, 1'b0);
    vectors++;
    if (dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: got v=%b, expected 0", dout_valid);
    end
  endtask

  task automatic test_gaps;
    logic [6:0] en_pat;
    logic [3:0] w;
    int k;
    en_pat = 7'b1011011;
    w = 4'h6;
    k = 0;
    dout_ready = 1'b0;
    exp_q.push_back(w);
    for (int c = 0; c < 7; c++) begin
      if (en_pat[6-c]) begin
        drive(1'b1, (k == 0), frame_bit(w, k));
        k++;
      end else begin
        drive(1'b0, 1'b0, 1'b1);
      end
    end
    if (FL == 5) drive(1'b1, 1'b0, frame_bit(w, 4));
    exp_w = exp_q.pop_front();
    for (int h = 0; h < 3; h++) begin
      vectors++;
      if (dout_valid !== 1'b1 || dout !== exp_w) begin
        miscompares++;
        $display("FAIL gaps_hold%0d: got v=%b dout=%h, expected v=1 dout=%h", h, dout_valid, dout, exp_w);
      end
      drive(1'b0, 1'b0, 1'b0);
    end
    $display("tb: gapped frame dout=%h", dout);
    dout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    dout_ready = 1'b0;
    vectors++;
    if (dout_valid !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_drain: got v=%b ovr=%b, expected v=0 ovr=0", dout_valid, overrun);
    end
  endtask

  task automatic test_overrun;
    dout_ready = 1'b0;
    exp_q.push_back(4'hA);
    send_frame(4'hA);
    send_frame(4'h5);
    exp_w = exp_q.pop_front();
    vectors++;
    if (dout !== exp_w || dout_valid !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: got dout=%h v=%b ovr=%b, expected dout=%h v=1 ovr=1", dout, dout_valid, overrun, exp_w);
    end
    $display("tb: overrun frame dout=%h ovr=%b", dout, overrun);
    clr_ovr = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    vectors++;
    if (overrun !== 1'b0 || dout !== exp_w) begin
      miscompares++;
      $display("FAIL overrun_clear: got ovr=%b dout=%h, expected ovr=0 dout=%h", overrun, dout, exp_w);
    end
    dout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    dout_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0] w;
    dout_ready = 1'b0;
    exp_q.push_back(4'h3);
    send_frame(4'h3);
    exp_w = exp_q.pop_front();
    vectors++;
    if (dout !== exp_w || dout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got dout=%h v=%b, expected dout=%h v=1", dout, dout_valid, exp_w);
    end
    w = 4'hC;
    exp_q.push_back(w);
    for (int i = 0; i < FL - 1; i++) drive(1'b1, (i == 0), frame_bit(w, i));
    dout_ready = 1'b1;
    drive(1'b1, 1'b0, frame_bit(w, FL - 1));
    exp_w = exp_q.pop_front();
    vectors++;
    if (dout !== exp_w || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_replace: got dout=%h v=%b ovr=%b, expected dout=%h v=1 ovr=0", dout, dout_valid, overrun, exp_w);
    end
    $display("tb: back-to-back replace dout=%h", dout);
    // sof in the very next cycle after completion
    w = 4'h9;
    exp_q.push_back(w);
    drive(1'b1, 1'b1, frame_bit(w, 0));
    vectors++;
    if (dout_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: got v=%b busy=%b, expected v=0 busy=1", dout_valid, busy);
    end
    for (int i = 1; i < FL; i++) drive(1'b1, 1'b0, frame_bit(w, i));
    exp_w = exp_q.pop_front();
    vectors++;
    if (dout !== exp_w || dout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: got dout=%h v=%b, expected dout=%h v=1", dout, dout_valid, exp_w);
    end
    $display("tb: back-to-back second dout=%h", dout);
    drive(1'b0, 1'b0, 1'b0);
    dout_ready = 1'b0;
  endtask

  task automatic test_abort;
    dout_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    vectors++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_partial: got busy=%b v=%b, expected busy=1 v=0", busy, dout_valid);
    end
    exp_q.push_back(4'h7);
    send_frame(4'h7);
    exp_w = exp_q.pop_front();
    vectors++;
    if (dout !== exp_w || dout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_word: got dout=%h v=%b, expected dout=%h v=1", dout, dout_valid, exp_w);
    end
    $display("tb: aborted then restarted frame dout=%h", dout);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    vectors++;
    if (dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_extra: got v=%b, expected 0", dout_valid);
    end
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_midframe;
    dout_ready = 1'b0;
    exp_q.push_back(4'hE);
    send_frame(4'hE);
    exp_w = exp_q.pop_front();
    vectors++;
    if (dout !== exp_w || dout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pending: got dout=%h v=%b, expected dout=%h v=1", dout, dout_valid, exp_w);
    end
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({dout, dout_valid, busy, overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL midrst_async: got dout=%h v=%b busy=%b ovr=%b, expected all 0", dout, dout_valid, busy, overrun);
    end
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    vectors++;
    if ({dout, dout_valid, busy, overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL midrst_after: got dout=%h v=%b busy=%b ovr=%b, expected all 0", dout, dout_valid, busy, overrun);
    end
    $display("tb: reset mid-frame cleared outputs");
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity;
    logic [1:0] pbits;
    logic [1:0] perr_exp;
    pbits    = 2'b10;
    perr_exp = 2'b01;
    dout_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(4'hB);
      for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), frame_bit(4'hB, i));
      vectors++;
      if (dout_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL parity_wait%0d: got v=%b busy=%b, expected v=0 busy=1", f, dout_valid, busy);
      end
      drive(1'b1, 1'b0, pbits[1-f]);
      exp_w = exp_q.pop_front();
      vectors++;
      if (dout_valid !== 1'b1 || dout !== exp_w || par_err !== perr_exp[1-f]) begin
        miscompares++;
        $display("FAIL parity_word%0d: got v=%b dout=%h perr=%b, expected v=1 dout=%h perr=%b", f, dout_valid, dout, par_err, exp_w, perr_exp[1-f]);
      end
      $display("tb: parity frame dout=%h par_err=%b", dout, par_err);
      drive(1'b0, 1'b0, 1'b0);
    end
    dout_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
